perceptron_layer_sequencer: RTL and testbench

- Time-multiplexed controller for the 8-neuron binary-input perceptron layer.
- Holds per-neuron weights and thresholds in a software-loadable register file, replacing fixed constant weights with runtime configuration.
- Sequences one shared multiply-accumulate/compare unit across all neurons and inputs.
- Publishes an 8-bit firing vector with a done strobe. It sits between the pin-level wrapper (ui_in/uo_out/uio) and the config/start control.

---
 rtl/perceptron_pkg.sv | 32 +++
 rtl/perceptron_mac_unit.sv | 51 +++++
 rtl/perceptron_layer_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_perceptron_layer_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// -----------------------------------------------------------------------------
// perceptron_pkg
// Shared constants, types and the sequencer state encoding for the
// time-multiplexed 8-neuron binary-input perceptron layer.
//   N_NEURONS / N_INPUTS : layer geometry (neurons per run, inputs per neuron)
//   W_WIDTH              : unsigned weight / threshold width
//   ACC_WIDTH            : accumulator width, holds N_INPUTS * max weight
//   CFG_SEL_THR          : cfg_sel code that addresses a neuron's threshold
// -----------------------------------------------------------------------------
package perceptron_pkg;

    localparam int N_NEURONS    = 8;
    localparam int N_INPUTS     = 8;
    localparam int W_WIDTH      = 8;
    localparam int ACC_WIDTH    = 11;
    localparam int CFG_SEL_THR  = 8;

    localparam int NEURON_IDX_W = $clog2(N_NEURONS);
    localparam int INPUT_IDX_W  = $clog2(N_INPUTS);
    localparam int CFG_SEL_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [W_WIDTH-1:0]   weight_t;
    typedef logic [ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/perceptron_mac_unit.sv
// -----------------------------------------------------------------------------
// perceptron_mac_unit
// Shared accumulate/compare datapath used by every neuron in turn.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the accumulator (wins over en)
//   en         : accumulate this cycle; weight is added only when x_bit is 1
//   cmp        : qualify the comparator result onto fire
//   x_bit      : binary input selecting whether weight is added
//   weight     : weight for the current (neuron, input) pair
//   thr        : threshold of the current neuron
//   fire       : cmp && (acc > thr), from the pre-clear accumulator value
// -----------------------------------------------------------------------------
module perceptron_mac_unit
    import perceptron_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clr,
    input  logic    en,
    input  logic    cmp,
    input  logic    x_bit,
    input  weight_t weight,
    input  weight_t thr,
    output logic    fire
);

    acc_t acc_q;
    acc_t acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en && x_bit) begin
            // ACC_WIDTH is sized so the full sum can never wrap.
            acc_d = acc_q + acc_t'(weight);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Strictly greater: a sum equal to the threshold does not fire.
    assign fire = cmp && (acc_q > acc_t'(thr));

endmodule

// File: rtl/perceptron_layer_sequencer.sv
// -----------------------------------------------------------------------------
// perceptron_layer_sequencer
// Evaluates an 8-neuron binary-input perceptron layer by stepping one shared
// MAC/compare unit over every (neuron, input) pair: 8 accumulate cycles plus
// one compare cycle per neuron, then a one-cycle DONE that publishes y.
//   clk, rst_n   : clock, asynchronous active-low reset
//   x            : binary input vector, latched when start is accepted
//   start        : request a layer evaluation (honoured only in IDLE)
//   cfg_we       : config write strobe
//   cfg_neuron   : neuron addressed by the write
//   cfg_sel      : 0..7 weight index, 8 threshold, 9..15 silently ignored
//   cfg_data     : value written
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse, y freshly valid
//   y            : firing vector, bit n = neuron n, held between runs
//   cfg_err      : one-cycle pulse after a cfg_we issued while busy
// -----------------------------------------------------------------------------
module perceptron_layer_sequencer
    import perceptron_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_INPUTS-1:0]     x,
    input  logic                    start,
    input  logic                    cfg_we,
    input  logic [NEURON_IDX_W-1:0] cfg_neuron,
    input  logic [CFG_SEL_W-1:0]    cfg_sel,
    input  logic [W_WIDTH-1:0]      cfg_data,
    output logic                    busy,
    output logic                    done,
    output logic [N_NEURONS-1:0]    y,
    output logic                    cfg_err
);

    localparam logic [INPUT_IDX_W-1:0]  LAST_INPUT  = INPUT_IDX_W'(N_INPUTS - 1);
    localparam logic [NEURON_IDX_W-1:0] LAST_NEURON = NEURON_IDX_W'(N_NEURONS - 1);
    localparam logic [CFG_SEL_W-1:0]    SEL_THR     = CFG_SEL_W'(CFG_SEL_THR);

    // ---------------------------------------------------------------- state
    state_t                  state_q,  state_d;
    logic [NEURON_IDX_W-1:0] n_q,      n_d;
    logic [INPUT_IDX_W-1:0]  i_q,      i_d;
    logic [N_INPUTS-1:0]     x_q,      x_d;
    logic [N_NEURONS-1:0]    shadow_q, shadow_d;
    logic [N_NEURONS-1:0]    y_q,      y_d;
    logic                    busy_q,   busy_d;
    logic                    done_q,   done_d;
    logic                    cfg_err_q, cfg_err_d;

    // A write landing in the same cycle as an accepted start must not be seen
    // by that run. The overwritten value is parked here together with its
    // address and substituted on reads of that address until the run ends.
    logic                    ovr_valid_q,  ovr_valid_d;
    logic [NEURON_IDX_W-1:0] ovr_neuron_q, ovr_neuron_d;
    logic [CFG_SEL_W-1:0]    ovr_sel_q,    ovr_sel_d;
    weight_t                 ovr_val_q,    ovr_val_d;

    // -------------------------------------------------------- register file
    weight_t w_q   [N_NEURONS][N_INPUTS];
    weight_t w_d   [N_NEURONS][N_INPUTS];
    weight_t thr_q [N_NEURONS];
    weight_t thr_d [N_NEURONS];

    logic cfg_wr_en;
    assign cfg_wr_en = cfg_we && (state_q == IDLE) && (cfg_sel <= SEL_THR);

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
            for (gj = 0; gj < N_INPUTS; gj++) begin : g_input
                assign w_d[gi][gj] = (cfg_wr_en &&
                                      cfg_neuron == NEURON_IDX_W'(gi) &&
                                      cfg_sel == CFG_SEL_W'(gj))
                                     ? cfg_data : w_q[gi][gj];
            end
            assign thr_d[gi] = (cfg_wr_en &&
                                cfg_neuron == NEURON_IDX_W'(gi) &&
                                cfg_sel == SEL_THR)
                               ? cfg_data : thr_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q   <= '{default: '0};
            thr_q <= '{default: '0};
        end else begin
            w_q   <= w_d;
            thr_q <= thr_d;
        end
    end

    // Pre-write contents of the address targeted by cfg_*, used to fill the
    // override slot on a start+write collision.
    weight_t cfg_old_val;
    assign cfg_old_val = (cfg_sel == SEL_THR) ? thr_q[cfg_neuron]
                                              : w_q[cfg_neuron][cfg_sel[INPUT_IDX_W-1:0]];

    // Run-time reads, with the override slot taking precedence.
    weight_t w_rd;
    weight_t thr_rd;
    assign w_rd   = (ovr_valid_q && ovr_neuron_q == n_q && ovr_sel_q == CFG_SEL_W'(i_q))
                    ? ovr_val_q : w_q[n_q][i_q];
    assign thr_rd = (ovr_valid_q && ovr_neuron_q == n_q && ovr_sel_q == SEL_THR)
                    ? ovr_val_q : thr_q[n_q];

    // ------------------------------------------------------------- datapath
    logic mac_clr;
    logic mac_en;
    logic mac_cmp;
    logic mac_fire;

    perceptron_mac_unit u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (mac_clr),
        .en     (mac_en),
        .cmp    (mac_cmp),
        .x_bit  (x_q[i_q]),
        .weight (w_rd),
        .thr    (thr_rd),
        .fire   (mac_fire)
    );

    // ------------------------------------------------------ next-state logic
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        i_d          = i_q;
        x_d          = x_q;
        shadow_d     = shadow_q;
        y_d          = y_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cfg_err_d    = cfg_we && (state_q != IDLE);
        ovr_valid_d  = ovr_valid_q;
        ovr_neuron_d = ovr_neuron_q;
        ovr_sel_d    = ovr_sel_q;
        ovr_val_d    = ovr_val_q;
        mac_clr      = 1'b0;
        mac_en       = 1'b0;
        mac_cmp      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = ACC;
                    busy_d       = 1'b1;
                    x_d          = x;
                    n_d          = '0;
                    i_d          = '0;
                    shadow_d     = '0;
                    mac_clr      = 1'b1;
                    ovr_valid_d  = cfg_wr_en;
                    ovr_neuron_d = cfg_neuron;
                    ovr_sel_d    = cfg_sel;
                    ovr_val_d    = cfg_old_val;
                end
            end
            ACC: begin
                mac_en = 1'b1;
                if (i_q == LAST_INPUT) begin
                    state_d = CMP;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            CMP: begin
                mac_cmp       = 1'b1;
                mac_clr       = 1'b1;
                shadow_d[n_q] = mac_fire;
                i_d           = '0;
                if (n_q == LAST_NEURON) begin
                    // y only ever moves here, so partial results stay hidden.
                    y_d     = shadow_d;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    n_d     = n_q + 1'b1;
                    state_d = ACC;
                end
            end
            DONE: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                ovr_valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            n_q          <= '0;
            i_q          <= '0;
            x_q          <= '0;
            shadow_q     <= '0;
            y_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            ovr_valid_q  <= 1'b0;
            ovr_neuron_q <= '0;
            ovr_sel_q    <= '0;
            ovr_val_q    <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            i_q          <= i_d;
            x_q          <= x_d;
            shadow_q     <= shadow_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            ovr_valid_q  <= ovr_valid_d;
            ovr_neuron_q <= ovr_neuron_d;
            ovr_sel_q    <= ovr_sel_d;
            ovr_val_q    <= ovr_val_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign y       = y_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_perceptron_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_perceptron_layer_sequencer
// Directed stimulus with hand-computed expected firing vectors. Each accepted
// start pushes {expected y, expected done cycle} onto a scoreboard; a monitor
// pops and checks on every done pulse, and likewise for cfg_err pulses.
// -----------------------------------------------------------------------------
module tb_perceptron_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] x = '0;
    logic       start = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_neuron = '0;
    logic [3:0] cfg_sel = '0;
    logic [7:0] cfg_data = '0;
    logic       busy;
    logic       done;
    logic [7:0] y;
    logic       cfg_err;

    perceptron_layer_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .start      (start),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .busy       (busy),
        .done       (done),
        .y          (y),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] y;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   err_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("y", int'(y), int'(e.y));
                chk("done_cycle", cyc, e.cyc);
                $display("[TB] done at cycle %0d y=%02h (expected %02h)", cyc, y, e.y);
            end
        end
        if (rst_n && cfg_err) begin
            if (err_q.size() == 0) begin
                chk("unexpected_cfg_err", 1, 0);
            end else begin
                chk("cfg_err_cycle", cyc, err_q.pop_front());
                $display("[TB] cfg_err at cycle %0d", cyc);
            end
        end
    end

    // ------------------------------------------------------------------ tasks
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_write(input int n, input int sel, input int d);
        cfg_we     = 1'b1;
        cfg_neuron = 3'(n);
        cfg_sel    = 4'(sel);
        cfg_data   = 8'(d);
        @(negedge clk);
        cfg_we     = 1'b0;
    endtask

    // Raises start for one cycle; with push set, records the expected result.
    task automatic issue_start(input logic [7:0] xv, input logic [7:0] exp_y,
                               input bit push);
        exp_t e;
        start = 1'b1;
        x     = xv;
        if (push) begin
            e.y   = exp_y;
            e.cyc = cyc + 73;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input logic [7:0] xv, input logic [7:0] exp_y);
        $display("[TB] start x=%02h expect y=%02h", xv, exp_y);
        issue_start(xv, exp_y, 1'b1);
        wait_drain();
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        int wts[8];
        int c0;
        wts = '{2, 4, 2, 1, 5, 2, 2, 2};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_y", int'(y), 0);
        chk("reset_cfg_err", int'(cfg_err), 0);

        // Neuron 0 weights, thr 0
        for (int i = 0; i < 8; i++) cfg_write(0, i, wts[i]);
        cfg_write(0, 8, 0);
        run(8'h00, 8'h00);
        run(8'h01, 8'h01);

        // Strict boundary: 9 == 9 does not fire, 14 > 9 does
        cfg_write(0, 8, 9);
        run(8'h0F, 8'h00);
        run(8'h1F, 8'h01);

        // Full-scale sums, no overflow
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 8; i++) cfg_write(n, i, 255);
            cfg_write(n, 8, 254);
        end
        run(8'hFF, 8'hFF);
        run(8'h00, 8'h00);

        // Busy handling: cfg_we at cycle 20, start at cycle 40
        do_reset();
        c0 = cyc;
        $display("[TB] start x=01 expect y=00 (busy test)");
        issue_start(8'h01, 8'h00, 1'b1);
        while (cyc < c0 + 20) @(negedge clk);
        err_q.push_back(c0 + 21);
        cfg_write(3, 0, 7);
        while (cyc < c0 + 40) @(negedge clk);
        chk("busy_mid_run", int'(busy), 1);
        issue_start(8'hFF, 8'h00, 1'b0);
        wait_drain();
        chk("cfg_err_drained", err_q.size(), 0);
        run(8'h01, 8'h00);

        // Reset mid-run
        cfg_write(2, 0, 50);
        run(8'h01, 8'h04);
        c0 = cyc;
        issue_start(8'h01, 8'h00, 1'b0);
        while (cyc < c0 + 30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_y", int'(y), 0);
        chk("midrst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (90) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        run(8'h01, 8'h00);

        // Ignored selector, then same-cycle start + write
        do_reset();
        cfg_write(1, 9, 200);
        cfg_write(1, 8, 5);
        cfg_we     = 1'b1;
        cfg_neuron = 3'd1;
        cfg_sel    = 4'd0;
        cfg_data   = 8'd9;
        $display("[TB] start x=01 with same-cycle write, expect y=00");
        issue_start(8'h01, 8'h00, 1'b1);
        cfg_we = 1'b0;
        wait_drain();
        run(8'h01, 8'h02);

        chk("err_queue_empty", err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
